// File: rtl/sky130_fd_io__xres_filt_pkg.sv
// Shared definitions for the clocked XRES filter block.
//   xres_state_t : per-channel filter FSM state encoding
//   xres_cnt_w   : width of the shared filter/stretch counter
package sky130_fd_io__xres_filt_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        FILT_ASSERT  = 2'b01,
        ASSERTED     = 2'b10,
        FILT_RELEASE = 2'b11
    } xres_state_t;

    // One counter serves both the filter window and the stretch, so it
    // must hold the larger of the two terminal values.
    function automatic int xres_cnt_w(input int filt_cycles, input int stretch_cycles);
        int m;
        m = (filt_cycles > stretch_cycles) ? filt_cycles : stretch_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sky130_fd_io__xres_filt_ch.sv
// One XRES channel: input select, reset-to-1 synchronizer, glitch filter
// FSM with assertion stretcher, and a sticky glitch flag.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_pad, i_filt_in : raw pad level / alternate input (1 = released)
//   i_inp_sel        : 1 selects i_filt_in, 0 selects i_pad
//   i_force          : forces ASSERTED with the stretch restarted
//   i_clr_err        : clears the sticky glitch flag (a same-cycle set wins)
//   o_xres_n         : registered filtered reset (0 = asserted)
//   o_glitch_flag    : sticky, a pulse shorter than the filter was rejected
//   o_state          : current FSM state for observation
module sky130_fd_io__xres_filt_ch
    import sky130_fd_io__xres_filt_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_CYCLES    = 8,
    parameter int STRETCH_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pad,
    input  logic        i_filt_in,
    input  logic        i_inp_sel,
    input  logic        i_force,
    input  logic        i_clr_err,
    output logic        o_xres_n,
    output logic        o_glitch_flag,
    output xres_state_t o_state
);

    localparam logic [CNT_W-1:0] FILT_MAX    = CNT_W'(FILT_CYCLES);
    localparam logic [CNT_W-1:0] STRETCH_MAX = CNT_W'(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sel;
    logic                   w_in;
    xres_state_t            r_state;
    xres_state_t            w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_glitch_set;
    logic                   r_xres_n;
    logic                   r_glitch;

    // Select is applied ahead of the synchronizer, so switching sources
    // mid-filter only changes the sampled level; the FSM carries on.
    assign w_sel = i_inp_sel ? i_filt_in : i_pad;
    assign w_in  = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_sel};
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_glitch_set = 1'b0;
        if (i_force) begin
            // Stretch restarts from zero so release after a force always
            // takes the full stretch plus the release filter.
            w_state_nxt = ASSERTED;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                RELEASED: begin
                    if (!w_in) begin
                        w_state_nxt = FILT_ASSERT;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                FILT_ASSERT: begin
                    if (w_in) begin
                        w_state_nxt  = RELEASED;
                        w_glitch_set = 1'b1;
                    end else if (r_cnt == FILT_MAX) begin
                        w_state_nxt = ASSERTED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ASSERTED: begin
                    if (w_in && (r_cnt >= STRETCH_MAX)) begin
                        w_state_nxt = FILT_RELEASE;
                        w_cnt_nxt   = CNT_ONE;
                    end else if (r_cnt < STRETCH_MAX) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                FILT_RELEASE: begin
                    if (!w_in) begin
                        // Back to ASSERTED with the stretch already served.
                        w_state_nxt  = ASSERTED;
                        w_cnt_nxt    = STRETCH_MAX;
                        w_glitch_set = 1'b1;
                    end else if (r_cnt == FILT_MAX) begin
                        w_state_nxt = RELEASED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ASSERTED;
                    w_cnt_nxt   = STRETCH_MAX;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ASSERTED;
            r_cnt    <= STRETCH_MAX;
            r_xres_n <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            // Output decoded from the next state so it lands on the same
            // edge as the state change.
            r_xres_n <= (w_state_nxt == RELEASED) || (w_state_nxt == FILT_ASSERT);
            r_glitch <= w_glitch_set | (r_glitch & ~i_clr_err);
        end
    end

    assign o_xres_n      = r_xres_n;
    assign o_glitch_flag = r_glitch;
    assign o_state       = r_state;

endmodule

// File: rtl/sky130_fd_io__xres_filt_nch.sv
// Multi-channel clocked XRES filter. Holds the shared force logic, the
// enable-sequencing error flag and the combined reset output.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   PAD           : raw pad level per channel (1 = released)
//   FILT_IN_H     : alternate input per channel
//   INP_SEL_H     : per-channel select, 1 = FILT_IN_H
//   PWR_GOOD_H    : supply good (CLK domain)
//   ENABLE_H      : block enable (CLK domain)
//   ENABLE_VDDIO  : VDDIO-path enable (CLK domain)
//   CLR_ERR       : clears sticky flags (a same-cycle set wins)
//   XRES_H_N      : filtered reset per channel (0 = asserted)
//   XRES_ALL_N    : registered AND of XRES_H_N
//   GLITCH_FLAG   : sticky per-channel rejected-glitch flag
//   SEQ_ERR       : sticky enable-sequencing violation
//   DBG_STATE     : per-channel FSM state, 2 bits per channel
module sky130_fd_io__xres_filt_nch
    import sky130_fd_io__xres_filt_pkg::*;
#(
    parameter int NCH            = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_CYCLES    = 8,
    parameter int STRETCH_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NCH-1:0]   PAD,
    input  logic [NCH-1:0]   FILT_IN_H,
    input  logic [NCH-1:0]   INP_SEL_H,
    input  logic             PWR_GOOD_H,
    input  logic             ENABLE_H,
    input  logic             ENABLE_VDDIO,
    input  logic             CLR_ERR,
    output logic [NCH-1:0]   XRES_H_N,
    output logic             XRES_ALL_N,
    output logic [NCH-1:0]   GLITCH_FLAG,
    output logic             SEQ_ERR,
    output logic [2*NCH-1:0] DBG_STATE
);

    localparam int CNT_W = xres_cnt_w(FILT_CYCLES, STRETCH_CYCLES);

    logic           r_en_h_q;
    logic           r_en_vddio_q;
    logic           r_seq_err;
    logic           r_all_n;
    logic           w_seq_set;
    logic           w_force;
    logic [NCH-1:0] w_xres_n;

    // Both enables changing on the same edge means the power-up/down
    // ordering between the two domains was lost.
    assign w_seq_set = (ENABLE_H != r_en_h_q) && (ENABLE_VDDIO != r_en_vddio_q);

    // ENABLE_H without ENABLE_VDDIO is the hold-off window: keep resets low.
    assign w_force = !PWR_GOOD_H || r_seq_err || (ENABLE_H && !ENABLE_VDDIO);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_en_h_q     <= 1'b0;
            r_en_vddio_q <= 1'b0;
            r_seq_err    <= 1'b0;
            r_all_n      <= 1'b0;
        end else begin
            r_en_h_q     <= ENABLE_H;
            r_en_vddio_q <= ENABLE_VDDIO;
            r_seq_err    <= w_seq_set | (r_seq_err & ~CLR_ERR);
            r_all_n      <= &w_xres_n;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        xres_state_t w_state;

        sky130_fd_io__xres_filt_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .FILT_CYCLES    (FILT_CYCLES),
            .STRETCH_CYCLES (STRETCH_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .i_clk         (CLK),
            .i_rst         (RST),
            .i_pad         (PAD[g]),
            .i_filt_in     (FILT_IN_H[g]),
            .i_inp_sel     (INP_SEL_H[g]),
            .i_force       (w_force),
            .i_clr_err     (CLR_ERR),
            .o_xres_n      (w_xres_n[g]),
            .o_glitch_flag (GLITCH_FLAG[g]),
            .o_state       (w_state)
        );

        assign DBG_STATE[2*g +: 2] = w_state;
    end

    assign XRES_H_N   = w_xres_n;
    assign XRES_ALL_N = r_all_n;
    assign SEQ_ERR    = r_seq_err;

endmodule

// File: tb/tb_sky130_fd_io__xres_filt_nch.sv
// Directed bench for the multi-channel XRES filter.
// Observed vector: {XRES_ALL_N, SEQ_ERR, GLITCH_FLAG[3:0], XRES_H_N[3:0]}.
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. "edge N" means just after the Nth rising edge
// following the stimulus change.
module tb_sky130_fd_io__xres_filt_nch;

    localparam int NCH = 4;
    localparam int W   = 10;

    logic           CLK;
    logic           RST;
    logic [NCH-1:0] PAD;
    logic [NCH-1:0] FILT_IN_H;
    logic [NCH-1:0] INP_SEL_H;
    logic           PWR_GOOD_H;
    logic           ENABLE_H;
    logic           ENABLE_VDDIO;
    logic           CLR_ERR;
    logic [NCH-1:0] XRES_H_N;
    logic           XRES_ALL_N;
    logic [NCH-1:0] GLITCH_FLAG;
    logic           SEQ_ERR;
    logic [2*NCH-1:0] DBG_STATE;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_total;
    int           n_bad;

    sky130_fd_io__xres_filt_nch #(
        .NCH            (4),
        .SYNC_STAGES    (2),
        .FILT_CYCLES    (8),
        .STRETCH_CYCLES (16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .PAD          (PAD),
        .FILT_IN_H    (FILT_IN_H),
        .INP_SEL_H    (INP_SEL_H),
        .PWR_GOOD_H   (PWR_GOOD_H),
        .ENABLE_H     (ENABLE_H),
        .ENABLE_VDDIO (ENABLE_VDDIO),
        .CLR_ERR      (CLR_ERR),
        .XRES_H_N     (XRES_H_N),
        .XRES_ALL_N   (XRES_ALL_N),
        .GLITCH_FLAG  (GLITCH_FLAG),
        .SEQ_ERR      (SEQ_ERR),
        .DBG_STATE    (DBG_STATE)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] ev(input logic all_n, input logic seq,
                                        input logic [3:0] gl, input logic [3:0] xr);
        return {all_n, seq, gl, xr};
    endfunction

    function automatic logic [W-1:0] obs();
        return {XRES_ALL_N, SEQ_ERR, GLITCH_FLAG, XRES_H_N};
    endfunction

    task automatic push(input string tag, input logic [W-1:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Scoreboard
    task automatic pop_check();
        logic [W-1:0] e;
        logic [W-1:0] o;
        string        t;
        n_total++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty observed=%b required=queued_entry", obs());
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = obs();
            assert (o === e) else begin
                n_bad++;
                $error("FAIL %s observed=%b expected=%b state=%h", t, o, e, DBG_STATE);
            end
        end
    endtask

    task automatic wait_chk(input int n);
        repeat (n) tick();
        pop_check();
    endtask

    task automatic clr_pulse();
        CLR_ERR = 1'b1;
        tick();
        CLR_ERR = 1'b0;
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        RST          = 1'b1;
        PAD          = 4'hF;
        FILT_IN_H    = 4'hF;
        INP_SEL_H    = 4'h0;
        PWR_GOOD_H   = 1'b1;
        ENABLE_H     = 1'b0;
        ENABLE_VDDIO = 1'b0;
        CLR_ERR      = 1'b0;

        // Reset: everything low; stretch counter preloaded, so release is
        // just the 8-cycle release filter plus the exit edge.
        repeat (3) tick();
        push("rst_state", ev(1'b0, 1'b0, 4'h0, 4'h0));
        wait_chk(0);
        RST = 1'b0;
        push("rst_hold", ev(1'b0, 1'b0, 4'h0, 4'h0));
        wait_chk(8);
        push("rst_release", ev(1'b0, 1'b0, 4'h0, 4'hF));
        wait_chk(1);
        push("rst_all_n", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(1);

        // 5-cycle low pulse on ch0: rejected, glitch flag at edge 8.
        PAD = 4'hE;
        push("g5_mid", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(5);
        PAD = 4'hF;
        push("g5_pre_flag", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(2);
        push("g5_flag", ev(1'b1, 1'b0, 4'h1, 4'hF));
        wait_chk(1);
        push("g5_sticky", ev(1'b1, 1'b0, 4'h1, 4'hF));
        wait_chk(6);
        clr_pulse();
        push("g5_cleared", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(0);

        // 8-cycle pulse on ch1: exactly the filter length, still rejected.
        PAD = 4'hD;
        push("g8_mid", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(8);
        PAD = 4'hF;
        push("g8_pre_flag", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(2);
        push("g8_flag", ev(1'b1, 1'b0, 4'h2, 4'hF));
        wait_chk(1);
        clr_pulse();
        push("g8_cleared", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(0);

        // 9-cycle pulse on ch0: asserts at edge 11, stretch then filter,
        // released at edge 36.
        PAD = 4'hE;
        push("a9_in_filter", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(9);
        PAD = 4'hF;
        push("a9_edge10", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(1);
        push("a9_assert", ev(1'b1, 1'b0, 4'h0, 4'hE));
        wait_chk(1);
        push("a9_all_n", ev(1'b0, 1'b0, 4'h0, 4'hE));
        wait_chk(1);
        push("a9_stretch", ev(1'b0, 1'b0, 4'h0, 4'hE));
        wait_chk(23);
        push("a9_release", ev(1'b0, 1'b0, 4'h0, 4'hF));
        wait_chk(1);
        push("a9_all_rel", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(1);

        // Input select on ch2: pad activity ignored while FILT_IN_H is 1.
        INP_SEL_H = 4'h4;
        for (int i = 0; i < 12; i++) begin
            PAD[2] = ~PAD[2];
            push("sel_pad_ignored", ev(1'b1, 1'b0, 4'h0, 4'hF));
            wait_chk(1);
        end
        PAD       = 4'hF;
        FILT_IN_H = 4'hB;
        push("sel_filter", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(10);
        push("sel_assert", ev(1'b1, 1'b0, 4'h0, 4'hB));
        wait_chk(1);
        FILT_IN_H = 4'hF;
        push("sel_stretch", ev(1'b0, 1'b0, 4'h0, 4'hB));
        wait_chk(24);
        push("sel_release", ev(1'b0, 1'b0, 4'h0, 4'hF));
        wait_chk(1);
        push("sel_all_rel", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(1);
        INP_SEL_H = 4'h0;

        // One-cycle power loss: forced low next edge, release at edge 26.
        PWR_GOOD_H = 1'b0;
        tick();
        PWR_GOOD_H = 1'b1;
        push("pwr_force", ev(1'b1, 1'b0, 4'h0, 4'h0));
        wait_chk(0);
        push("pwr_all_n", ev(1'b0, 1'b0, 4'h0, 4'h0));
        wait_chk(1);
        push("pwr_stretch", ev(1'b0, 1'b0, 4'h0, 4'h0));
        wait_chk(23);
        push("pwr_release", ev(1'b0, 1'b0, 4'h0, 4'hF));
        wait_chk(1);
        push("pwr_all_rel", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(1);

        // Both enables rise together: SEQ_ERR, then forced low.
        ENABLE_H     = 1'b1;
        ENABLE_VDDIO = 1'b1;
        push("seq_set", ev(1'b1, 1'b1, 4'h0, 4'hF));
        wait_chk(1);
        push("seq_force", ev(1'b1, 1'b1, 4'h0, 4'h0));
        wait_chk(1);
        push("seq_all_n", ev(1'b0, 1'b1, 4'h0, 4'h0));
        wait_chk(1);
        push("seq_sticky", ev(1'b0, 1'b1, 4'h0, 4'h0));
        wait_chk(5);
        // Clear collides with a falling double toggle: set wins.
        ENABLE_H     = 1'b0;
        ENABLE_VDDIO = 1'b0;
        CLR_ERR      = 1'b1;
        push("seq_set_wins", ev(1'b0, 1'b1, 4'h0, 4'h0));
        wait_chk(1);
        push("seq_cleared", ev(1'b0, 1'b0, 4'h0, 4'h0));
        wait_chk(1);
        CLR_ERR = 1'b0;
        push("seq_stretch", ev(1'b0, 1'b0, 4'h0, 4'h0));
        wait_chk(24);
        push("seq_release", ev(1'b0, 1'b0, 4'h0, 4'hF));
        wait_chk(1);
        push("seq_all_rel", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(1);

        // Hold-off: ENABLE_H first, ENABLE_VDDIO one cycle later.
        ENABLE_H = 1'b1;
        tick();
        ENABLE_VDDIO = 1'b1;
        push("hold_force", ev(1'b1, 1'b0, 4'h0, 4'h0));
        wait_chk(0);
        push("hold_stretch", ev(1'b0, 1'b0, 4'h0, 4'h0));
        wait_chk(24);
        push("hold_release", ev(1'b0, 1'b0, 4'h0, 4'hF));
        wait_chk(1);
        push("hold_all_rel", ev(1'b1, 1'b0, 4'h0, 4'hF));
        wait_chk(1);

        // Final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
